// File: rtl/ps2_keycode_collector_pkg.sv
// Shared types, HID key constants and the set-2 scan-code translation for the PS/2 keycode collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam int NUM_SLOTS = 4;

    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4f;
    localparam logic [7:0] KEY_W     = 8'h1a;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2c;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    localparam logic [7:0] PS2_EXT = 8'he0;
    localparam logic [7:0] PS2_BRK = 8'hf0;

    // Unlisted codes return KEY_NONE, which the slot table ignores.
    function automatic logic [7:0] ps2_to_hid(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        hid = KEY_NONE;
        case ({ext, code})
            {1'b1, 8'h75}: hid = KEY_UP;
            {1'b1, 8'h72}: hid = KEY_DOWN;
            {1'b1, 8'h6b}: hid = KEY_LEFT;
            {1'b1, 8'h74}: hid = KEY_RIGHT;
            {1'b0, 8'h1d}: hid = KEY_W;
            {1'b0, 8'h1c}: hid = KEY_A;
            {1'b0, 8'h1b}: hid = KEY_S;
            {1'b0, 8'h23}: hid = KEY_D;
            {1'b0, 8'h29}: hid = KEY_SPACE;
            {1'b0, 8'h5a}: hid = KEY_ENTER;
            default:       hid = KEY_NONE;
        endcase
        return hid;
    endfunction

endpackage

// File: rtl/ps2_keycode_collector_if.sv
// Pressed-key slot bus from the collector to the tank movement controllers.
// Latency: n/a (wires only).
// Backpressure: none; consumers sample the level-valued slots whenever they like.
interface ps2_keycode_collector_if;
    logic [31:0] keycode;
    logic        frame_err;

    modport master (output keycode, frame_err);
    modport slave  (input  keycode, frame_err);
endinterface

// File: rtl/ps2_keycode_collector_rx.sv
// PS/2 byte receiver: pin synchronizers, falling-edge detect, framing FSM and mid-frame watchdog.
// Latency: byte_valid/frame_err one cycle after the stop-bit edge is detected.
// Backpressure: none; the device clocks the bus, so every byte is presented exactly once.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC - 1);

    logic clk_s1, clk_s2, clk_s3;
    logic dat_s1, dat_s2;
    logic fall;

    rx_state_t       state;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic            par;
    logic [WD_W-1:0] wdog;

    // Both pins reset high, matching an idle bus, so no edge is seen out of reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= RX_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
            wdog       <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                wdog <= '0;
                case (state)
                    RX_IDLE: begin
                        if (!dat_s2) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par   <= dat_s2;
                        state <= RX_STOP;
                    end
                    RX_STOP: begin
                        if ((^{shreg, par}) && dat_s2) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end else if (state != RX_IDLE) begin
                // A device that stops clocking mid-frame would otherwise wedge the receiver.
                if (wdog == WD_LIM) begin
                    state     <= RX_IDLE;
                    frame_err <= 1'b1;
                    wdog      <= '0;
                end else begin
                    wdog <= wdog + WD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_collector.sv
// PS/2 set-2 make/break decoder feeding a 4-slot pressed-key table of HID codes.
// Latency: keycode updates two cycles after the stop-bit edge is detected.
// Backpressure: none; new presses are dropped when all four slots are occupied.
module ps2_keycode_collector
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           PS2_CLK,
    input  logic                           PS2_DAT,
    ps2_keycode_collector_if.master        kc
);
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_frame_err;

    logic       ext, brk;
    logic [7:0] slot [NUM_SLOTS];
    logic [7:0] hid;
    logic       present;
    logic       has_empty;
    logic [1:0] free_idx;

    ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .ps2_clk    (PS2_CLK),
        .ps2_dat    (PS2_DAT),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (rx_frame_err)
    );

    // Descending scan so the lowest empty index wins.
    always_comb begin
        hid       = ps2_to_hid(ext, rx_byte);
        present   = 1'b0;
        has_empty = 1'b0;
        free_idx  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot[i] == hid) present = 1'b1;
            if (slot[i] == KEY_NONE) begin
                has_empty = 1'b1;
                free_idx  = 2'(i);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext <= 1'b0;
            brk <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= KEY_NONE;
        end else if (byte_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (hid != KEY_NONE) begin
                    if (brk) begin
                        // Slots never compact, so held keys keep their lanes.
                        for (int i = 0; i < NUM_SLOTS; i++)
                            if (slot[i] == hid) slot[i] <= KEY_NONE;
                    end else if (!present && has_empty) begin
                        slot[free_idx] <= hid;
                    end
                end
            end
        end
    end

    assign kc.keycode   = {slot[3], slot[2], slot[1], slot[0]};
    assign kc.frame_err = rx_frame_err;

endmodule
